keypad_matrix_scan: RTL

Parametrised matrix-keypad scanner for ROWS x COLS switch arrays with active-low rows and one-cold column drive. It provides row synchronisation, settle-before-sample, press and release debounce, and optional auto-repeat. It emits a linear key index with a one-cycle valid strobe and a one-cycle release strobe. It sits between the keypad pins and the lock's code-entry logic, replacing the fixed 4x3 scanner.

---
 rtl/keypad_matrix_scan_if.sv | 38 +++
 rtl/keypad_matrix_scan.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan_if.sv
// rtl/keypad_matrix_scan_if.sv - pin and key-event bundle for keypad_matrix_scan
//
// Purpose: groups the keypad pins and the key-event outputs of the scanner.
//   master: the scanner (drives col and the key strobes, receives rows)
//   slave : keypad / code-entry side (drives rows and repeat_en)
//
// Signals:
//   row          keypad rows, pulled up, low = closed contact on driven column
//   repeat_en    auto-repeat enable
//   col          one-cold column drive
//   key_valid    one-cycle strobe: new key or repeat
//   key_code     row_idx*COLS + col_idx
//   key_repeat   high with key_valid when the strobe is a repeat
//   key_release  one-cycle strobe when the held key is debounced open

interface keypad_matrix_scan_if #(
   parameter int ROWS  = 4,
   parameter int COLS  = 3,
   parameter int KEY_W = 4
);
   logic [ROWS-1:0]  row;
   logic             repeat_en;
   logic [COLS-1:0]  col;
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             key_repeat;
   logic             key_release;

   modport master (
      input  row, repeat_en,
      output col, key_valid, key_code, key_repeat, key_release
   );

   modport slave (
      output row, repeat_en,
      input  col, key_valid, key_code, key_repeat, key_release
   );
endinterface

// File: rtl/keypad_matrix_scan.sv
// rtl/keypad_matrix_scan.sv - matrix keypad scanner with debounce and auto-repeat
//
// Purpose: drives one column low at a time, samples the synchronised
// active-low rows once the column has settled, debounces press and release of
// the first key found and reports it as a linear index, optionally repeating
// while the key is held.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   bus.row          keypad rows in
//   bus.repeat_en    auto-repeat enable, sampled every cycle
//   bus.col          one-cold column drive out
//   bus.key_valid    one-cycle strobe: new key or repeat
//   bus.key_code     row_idx*COLS + col_idx, changes only with key_valid
//   bus.key_repeat   high with key_valid when the strobe is a repeat
//   bus.key_release  one-cycle strobe when the held key is debounced open

module keypad_matrix_scan #(
   parameter int ROWS         = 4,
   parameter int COLS         = 3,
   parameter int KEY_W        = 4,
   parameter int SETTLE       = 16,
   parameter int DEBOUNCE     = 1_000_000,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   keypad_matrix_scan_if.master bus
);

   // One shared counter, wide enough for the longest interval.
   localparam int MAX_SD = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
   localparam int MAX_RP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int MAX_T  = (MAX_SD > MAX_RP) ? MAX_SD : MAX_RP;
   localparam int CNT_W  = (MAX_T > 4) ? $clog2(MAX_T) : 2;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW     = $clog2(COLS);

   localparam logic [CNT_W-1:0] SETTLE_T = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] DEB_T    = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] DELAY_T  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_T   = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CW-1:0]    LAST_COL = CW'(COLS - 1);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

   state_t           state, state_nx;

   logic [ROWS-1:0]  row_meta, row_s;
   logic [CNT_W-1:0] cnt;
   logic             rpt_later;     // 0: next repeat uses REPEAT_DELAY, 1: REPEAT_RATE
   logic [RW-1:0]    key_row;
   logic [RW-1:0]    first_row;
   logic [CW-1:0]    col_idx, col_nx;
   logic [COLS-1:0]  col_r;
   logic             key_valid_r, key_repeat_r, key_release_r;
   logic [KEY_W-1:0] key_code_r;

   logic             any_low, key_open, rpt_hit;
   logic             cnt_clr, cnt_inc, latch_key, col_adv;
   logic             valid_d, rpt_d, rel_d, phase_first, phase_later;

   // Rows idle high, so the synchroniser resets to "no key".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= '1;
         row_s    <= '1;
      end else begin
         row_meta <= bus.row;
         row_s    <= row_meta;
      end
   end

   // Lowest closed row wins when several rows pull low on one column.
   always_comb begin
      first_row = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!row_s[i]) first_row = RW'(i);
      end
   end

   assign any_low  = ~&row_s;
   assign key_open = row_s[key_row];
   assign rpt_hit  = (cnt == (rpt_later ? RATE_T : DELAY_T));
   assign col_nx   = (col_idx == LAST_COL) ? '0 : col_idx + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SCAN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SCAN:      if (cnt == SETTLE_T && any_low) state_nx = DEB_PRESS;
         DEB_PRESS: begin
            if (key_open)           state_nx = SCAN;
            else if (cnt == DEB_T)  state_nx = HELD;
         end
         HELD:      if (key_open)   state_nx = DEB_REL;
         DEB_REL: begin
            if (!key_open)          state_nx = HELD;
            else if (cnt == DEB_T)  state_nx = SCAN;
         end
         default:                   state_nx = SCAN;
      endcase
   end

   always_comb begin
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      latch_key   = 1'b0;
      col_adv     = 1'b0;
      valid_d     = 1'b0;
      rpt_d       = 1'b0;
      rel_d       = 1'b0;
      phase_first = 1'b0;
      phase_later = 1'b0;
      case (state)
         SCAN: begin
            if (cnt == SETTLE_T) begin
               cnt_clr = 1'b1;
               if (any_low) latch_key = 1'b1;
               else         col_adv   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DEB_PRESS: begin
            if (key_open) begin
               col_adv = 1'b1;
               cnt_clr = 1'b1;
            end else if (cnt == DEB_T) begin
               valid_d     = 1'b1;
               cnt_clr     = 1'b1;
               phase_first = 1'b1;   // a fresh key always starts with the long delay
            end else begin
               cnt_inc = 1'b1;
            end
         end
         HELD: begin
            // Release is checked first so it beats a coincident repeat.
            if (key_open) begin
               cnt_clr = 1'b1;
            end else if (!bus.repeat_en) begin
               cnt_clr     = 1'b1;
               phase_first = 1'b1;
            end else if (rpt_hit) begin
               valid_d     = 1'b1;
               rpt_d       = 1'b1;
               cnt_clr     = 1'b1;
               phase_later = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DEB_REL: begin
            if (!key_open) begin
               cnt_clr     = 1'b1;
               phase_first = 1'b1;
            end else if (cnt == DEB_T) begin
               rel_d   = 1'b1;
               col_adv = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   // The column stays put outside SCAN, so col_idx doubles as the latched column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         rpt_later     <= 1'b0;
         key_row       <= '0;
         col_idx       <= '0;
         col_r         <= ~COLS'(1);
         key_valid_r   <= 1'b0;
         key_repeat_r  <= 1'b0;
         key_release_r <= 1'b0;
         key_code_r    <= '0;
      end else begin
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CNT_W'(1);

         if (phase_first)      rpt_later <= 1'b0;
         else if (phase_later) rpt_later <= 1'b1;

         if (latch_key) key_row <= first_row;

         if (col_adv) begin
            col_idx <= col_nx;
            col_r   <= ~(COLS'(1) << col_nx);
         end

         key_valid_r   <= valid_d;
         key_repeat_r  <= rpt_d;
         key_release_r <= rel_d;
         if (valid_d) key_code_r <= KEY_W'(int'(key_row) * COLS + int'(col_idx));
      end
   end

   assign bus.col         = col_r;
   assign bus.key_valid   = key_valid_r;
   assign bus.key_code    = key_code_r;
   assign bus.key_repeat  = key_repeat_r;
   assign bus.key_release = key_release_r;

endmodule
